// File: rtl/dcache_responder_pkg.sv
// Shared constants for the dcache responder: FSM encodings, line geometry,
// memory request direction encoding and the store byte-merge helper.
package dcache_responder_pkg;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 4;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_REFILL_REQ  = 2'd1;
    localparam logic [1:0] ST_REFILL_WAIT = 2'd2;
    localparam logic [1:0] ST_WRITE_REQ   = 2'd3;

    localparam logic RNW_LINE_READ  = 1'b1;
    localparam logic RNW_WORD_WRITE = 1'b0;

    // Overlay the enabled byte lanes of din onto one word of a cache line.
    function automatic logic [127:0] merge_word(input logic [127:0] line,
                                                input logic [1:0]   word,
                                                input logic [31:0]  din,
                                                input logic [3:0]   we);
        logic [127:0] res;
        int           base;
        res = line;
        for (int b = 0; b < 4; b++) begin
            base = 32 * int'(word) + 8 * b;
            if (we[b]) res[base +: 8] = din[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid and tag storage for the direct-mapped dcache: async-cleared flops,
// combinational hit lookup and a single install write port.
module dcache_tag_array
    import dcache_responder_pkg::*;
#(
    parameter  int LINES = 64,
    localparam int IDX_W = $clog2(LINES),
    localparam int TAG_W = 32 - OFFSET_W - IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
        end
    end

    assign hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through, no-write-allocate dcache responder.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  dcache_addr,
    input  logic         dcache_re,
    input  logic [3:0]   dcache_we,
    input  logic [31:0]  dcache_din,
    output logic [31:0]  dcache_dout,
    output logic         stall,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_rnw,
    output logic [31:0]  mem_req_addr,
    output logic [31:0]  mem_req_wdata,
    output logic [3:0]   mem_req_wmask,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data,
`ifdef DCACHE_STATS_EN
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
`endif
    output logic [1:0]   dbg_state
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    // mem_req_* obey valid/ready: a request is raised with valid, held
    // stable while valid && !ready, and consumed on the valid && ready edge.
    logic [1:0]       state_q, state_d;
    logic [31:2]      req_addr_q;
    logic [31:0]      req_din_q;
    logic             req_re_q;
    logic [3:0]       req_we_q;
    logic             req_pend_q;
    logic [31:0]      dout_q;
    logic [127:0]     data_q [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word;
    logic             tag_hit, is_store, is_read, idle_active;
    logic             rd_hit, rd_miss, st_go, install, write_done;
    logic [127:0]     hit_line;
    logic [31:0]      hit_word, resp_word;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^dcache_addr[1:0];

    assign idx  = req_addr_q[OFFSET_W +: IDX_W];
    assign tag  = req_addr_q[31 -: TAG_W];
    assign word = req_addr_q[3:2];

    dcache_tag_array #(.LINES(LINES)) u_tags (
        .clk        (clk),
        .reset_n    (reset_n),
        .lookup_idx (idx),
        .lookup_tag (tag),
        .hit        (tag_hit),
        .wr_en      (install),
        .wr_idx     (idx),
        .wr_tag     (tag)
    );

    assign is_store    = |req_we_q;
    assign is_read     = req_re_q && !is_store;
    assign idle_active = (state_q == ST_IDLE) && req_pend_q;
    assign rd_hit      = idle_active && is_read && tag_hit;
    assign rd_miss     = idle_active && is_read && !tag_hit;
    assign st_go       = idle_active && is_store;
    assign install     = (state_q == ST_REFILL_WAIT) && mem_resp_valid;
    assign write_done  = (state_q == ST_WRITE_REQ) && mem_req_ready;

    assign hit_line  = data_q[idx];
    assign hit_word  = hit_line[{word, 5'b0} +: 32];
    assign resp_word = mem_resp_data[{word, 5'b0} +: 32];

    assign stall       = (state_q != ST_IDLE) || rd_miss || st_go;
    assign dcache_dout = rd_hit ? hit_word : dout_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (rd_miss) state_d = ST_REFILL_REQ;
                            else if (st_go) state_d = ST_WRITE_REQ;
            ST_REFILL_REQ:  if (mem_req_ready) state_d = ST_REFILL_WAIT;
            ST_REFILL_WAIT: if (mem_resp_valid) state_d = ST_IDLE;
            ST_WRITE_REQ:   if (mem_req_ready) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // A captured request stays pending until answered, so a refilled read or
    // a completed write is not replayed when the FSM returns to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            req_addr_q <= '0;
            req_din_q  <= '0;
            req_re_q   <= 1'b0;
            req_we_q   <= '0;
            req_pend_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= install ? resp_word : dcache_dout;
            if (!stall) begin
                req_addr_q <= dcache_addr[31:2];
                req_din_q  <= dcache_din;
                req_re_q   <= dcache_re;
                req_we_q   <= dcache_we;
                req_pend_q <= dcache_re || (|dcache_we);
            end else if (install || write_done) begin
                req_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (install) data_q[idx] <= mem_resp_data;
        else if (st_go && tag_hit) data_q[idx] <= merge_word(hit_line, word, req_din_q, req_we_q);
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_rnw   = RNW_WORD_WRITE;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        if (state_q == ST_REFILL_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_rnw   = RNW_LINE_READ;
            mem_req_addr  = {req_addr_q[31:4], 4'b0};
        end else if (state_q == ST_WRITE_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {req_addr_q[31:2], 2'b0};
            mem_req_wdata = req_din_q;
            mem_req_wmask = req_we_q;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
            if (rd_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: a word-level memory model and a
// line-presence model predict every load value, stall and memory request.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rnw;
    logic [31:0]  mem_req_addr;
    logic [31:0]  mem_req_wdata;
    logic [3:0]   mem_req_wmask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [1:0]   dbg_state;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    dcache_responder #(.LINES(64)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rnw    (mem_req_rnw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
`ifdef DCACHE_STATS_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .dbg_state      (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_hit    = 0;
    int n_miss   = 0;

    // Reference state: backing memory by word address, and which lines are cached.
    logic [31:0] mem_m [logic [31:0]];
    bit   [63:0] m_valid;
    logic [21:0] m_tag [64];
    logic [31:0] last_dout;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (mem_m.exists(wa)) return mem_m[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic mem_wr(input logic [31:0] wa, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] w;
        w = mem_rd(wa);
        for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_m[wa] = w;
    endtask

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_rd({a[31:4], 4'b0} + 32'(4 * w));
        return l;
    endfunction

    // One core access, carried through any stall while acting as backing memory.
    task automatic access(input logic [31:0] a, input logic re, input logic [3:0] we,
                          input logic [31:0] d, input int hold);
        logic [31:0] wa;
        logic [5:0]  idx;
        logic [21:0] tg;
        logic        hit, is_st, is_rd;
        int          lat;
        wa    = {a[31:2], 2'b0};
        idx   = a[9:4];
        tg    = a[31:10];
        is_st = |we;
        is_rd = re && !is_st;
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        dcache_addr = a; dcache_re = re; dcache_we = we; dcache_din = d;
        @(posedge clk); #1;
        if (!is_rd && !is_st) begin
            check("idle_stall", stall, 0);
            check("idle_dout", dcache_dout, last_dout);
        end else if (is_rd && hit) begin
            exp_q.push_back(mem_rd(wa));
            n_hit++;
            check("hit_stall", stall, 0);
            last_dout = exp_q.pop_front();
            check("hit_dout", dcache_dout, last_dout);
        end else if (is_rd) begin
            exp_q.push_back(mem_rd(wa));
            n_miss++;
            check("miss_stall", stall, 1);
            @(posedge clk); #1;
            for (int i = 0; i <= hold; i++) begin
                check("rf_valid", mem_req_valid, 1);
                check("rf_rnw", mem_req_rnw, 1);
                check("rf_addr", mem_req_addr, {a[31:4], 4'b0});
                check("rf_stall", stall, 1);
                if (i == hold) mem_req_ready = 1'b1;
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b0;
            lat = $urandom_range(0, 2);
            repeat (lat) begin
                check("rw_stall", stall, 1);
                check("rw_valid", mem_req_valid, 0);
                @(posedge clk); #1;
            end
            mem_resp_data  = mem_line(a);
            mem_resp_valid = 1'b1;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            mem_resp_data  = {4{$urandom}};
            check("rf_done_stall", stall, 0);
            last_dout = exp_q.pop_front();
            check("rf_dout", dcache_dout, last_dout);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end else begin
            check("st_stall", stall, 1);
            @(posedge clk); #1;
            for (int i = 0; i <= hold; i++) begin
                check("wr_valid", mem_req_valid, 1);
                check("wr_rnw", mem_req_rnw, 0);
                check("wr_addr", mem_req_addr, wa);
                check("wr_data", mem_req_wdata, d);
                check("wr_mask", mem_req_wmask, we);
                check("wr_stall", stall, 1);
                if (i == hold) mem_req_ready = 1'b1;
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b0;
            check("wr_done_stall", stall, 0);
            check("wr_dout_hold", dcache_dout, last_dout);
            mem_wr(wa, d, we);
        end
        dcache_re = 1'b0;
        dcache_we = 4'b0;
    endtask

    task automatic model_reset();
        m_valid   = '0;
        last_dout = '0;
        n_hit     = 0;
        n_miss    = 0;
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        dcache_addr = '0; dcache_re = 1'b0; dcache_we = '0; dcache_din = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_dout", dcache_dout, 0);
        check("rst_state", dbg_state, 2'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed: cold read, hit, partial store, uncached store, conflicts.
        access(32'h100, 1, 4'b0000, 0, 0);
        access(32'h104, 1, 4'b0000, 0, 0);
        access(32'h108, 0, 4'b0011, 32'hAABB_CCDD, 1);
        access(32'h108, 1, 4'b0000, 0, 0);
        check("merge_lo", dcache_dout[15:0], 16'hCCDD);
        access(32'h2000, 0, 4'b1111, 32'h1357_9BDF, 0);
        access(32'h2000, 1, 4'b0000, 0, 0);
        access(32'h100, 1, 4'b0000, 0, 0);
        access(32'h500, 1, 4'b0000, 0, 0);
        access(32'h100, 1, 4'b0000, 0, 0);
        access(32'h600, 1, 4'b0000, 0, 5);
        access(32'h604, 1, 4'b0100, 32'h5566_7788, 5);
        access(32'h604, 1, 4'b0000, 0, 0);

        // Spurious response while idle must be ignored.
        mem_resp_data  = {4{32'hDEAD_BEEF}};
        mem_resp_valid = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        check("spur_stall", stall, 0);
        check("spur_req", mem_req_valid, 0);
        check("spur_dout", dcache_dout, last_dout);
        access(32'h604, 1, 4'b0000, 0, 0);

        // Randomized mix over a small address pool so hits, misses and conflicts recur.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            int          k;
            a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            if (k <= 5)      access(a, 1, 4'b0000, $urandom, $urandom_range(0, 2));
            else if (k <= 8) access(a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2));
            else             access(a, 0, 4'b0000, $urandom, 0);
        end

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 32'(n_hit));
        check("miss_count", miss_count, 32'(n_miss));
`endif

        // Reset while a refill is outstanding.
        dcache_addr = 32'h3000; dcache_re = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("pre_rst_stall", stall, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_req", mem_req_valid, 0);
        check("midrst_dout", dcache_dout, 0);
        dcache_re = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        mem_resp_data  = {4{32'hBAD0_BAD0}};
        mem_resp_valid = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        check("late_resp_stall", stall, 0);
        check("late_resp_dout", dcache_dout, 0);
        access(32'h100, 1, 4'b0000, 0, 0);
        access(32'h3000, 1, 4'b0000, 0, 0);
        access(32'h3004, 1, 4'b0000, 0, 0);
        access(32'h104, 1, 4'b0000, 0, 0);
        access(32'h108, 1, 4'b0000, 0, 0);

`ifdef DCACHE_STATS_EN
        check("hit_count_rst", hit_count, 32'd3);
        check("miss_count_rst", miss_count, 32'd2);
`endif
        check("final_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
